ko_mult_arbiter: RTL and testbench

//  Shares one fixed-latency pipelined 256x256 Karatsuba multiplier among NUM_REQ requesters
//  (SM2 point-add/double and modular-reduction engines). Round-robin issue of one operand pair
//  per cycle, tracks requester ID through the multiplier pipeline, and buffers products in a

---
 rtl/ko_mult_arbiter.sv | 144 ++++++++++++++
 tb/tb_ko_mult_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ko_mult_arbiter.sv
// Round-robin front end for a shared fixed-latency pipelined multiplier. Requester IDs travel
// alongside the multiplier, and products land in a credit-protected fall-through FIFO.
module ko_mult_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ),
  parameter int WIDTH      = 256,
  parameter int MUL_LAT    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
  output logic [WIDTH-1:0]         mul_a_o,
  output logic [WIDTH-1:0]         mul_b_o,
  input  logic [2*WIDTH-1:0]       mul_res_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [2*WIDTH-1:0]       rsp_data_o,
  output logic                     busy_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(MUL_LAT + 1);

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [2*WIDTH-1:0] data;
  } rsp_t;

  logic [NUM_REQ-1:0][WIDTH-1:0] a_lane, b_lane;
  assign a_lane = req_a_i;
  assign b_lane = req_b_i;

  logic [ID_W-1:0]              last_q, last_d;
  logic [ID_W-1:0]              win;
  logic                         found, credit_ok, issue;
  logic [MUL_LAT-1:0]           tag_vld_q, tag_vld_d;
  logic [MUL_LAT-1:0][ID_W-1:0] tag_id_q, tag_id_d;
  logic [INF_W-1:0]             inflight;
  logic [PTR_W-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         push, pop;
  rsp_t                         mem_q [FIFO_DEPTH];
  rsp_t                         head;

  // Round-robin search starting just after the last completed grant.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(last_q) + 1 + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid_i[ID_W'(idx)]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LAT; i++) inflight = inflight + INF_W'(tag_vld_q[i]);
  end

  // Credits count both buffered and in-flight products; a pop this cycle is not reused.
  assign credit_ok = (int'(cnt_q) + int'(inflight)) < FIFO_DEPTH;
  assign issue     = credit_ok & found;
  assign last_d    = issue ? win : last_q;

  always_comb begin
    req_ready_o = '0;
    for (int g = 0; g < NUM_REQ; g++) req_ready_o[g] = issue && (win == ID_W'(g));
  end

  assign mul_a_o = issue ? a_lane[win] : '0;
  assign mul_b_o = issue ? b_lane[win] : '0;

  // Tag pipe mirrors the multiplier depth so the last stage lines up with mul_res_i.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = issue;
    tag_id_d[0]  = win;
    for (int i = 1; i < MUL_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  assign push = tag_vld_q[MUL_LAT-1];
  assign pop  = rsp_valid_o & rsp_ready_i;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = (wptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    if (pop)  rptr_d = (rptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q    <= ID_W'(NUM_REQ - 1);
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      last_q    <= last_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: nothing reads it unless the count says the entry is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= '{id: tag_id_q[MUL_LAT-1], data: mul_res_i};
  end

  assign head        = mem_q[rptr_q];
  assign rsp_valid_o = (cnt_q != '0);
  assign rsp_id_o    = rsp_valid_o ? head.id   : '0;
  assign rsp_data_o  = rsp_valid_o ? head.data : '0;
  assign busy_o      = (inflight != '0) | (cnt_q != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (cnt_q == CNT_W'(FIFO_DEPTH))));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready_o));
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(cnt_q) + int'(inflight)) <= FIFO_DEPTH);

endmodule

// File: tb/tb_ko_mult_arbiter.sv
// Directed bench for ko_mult_arbiter with a behavioural pipelined multiplier and
// an issue-order scoreboard of expected {id, product}.
module tb_ko_mult_arbiter;
  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int W   = 256;
  localparam int LAT = 3;
  localparam int DEP = 4;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [2*W-1:0] p;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_valid, req_ready;
  logic [NR-1:0][W-1:0]   a_drv, b_drv;
  logic [W-1:0]           mul_a, mul_b;
  logic [2*W-1:0]         mul_res;
  logic                   rsp_valid, rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [2*W-1:0]         rsp_data;
  logic                   busy;
  logic [LAT-1:0][2*W-1:0] mp;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ko_mult_arbiter #(.NUM_REQ(NR), .ID_W(IDW), .WIDTH(W), .MUL_LAT(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(a_drv), .req_b_i(b_drv),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_res_i(mul_res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .busy_o(busy)
  );

  // Stand-in for the shared multiplier: LAT register stages, reset with the arbiter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mp <= '0;
    else begin
      mp[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
      for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_res = mp[LAT-1];

  function automatic logic [2*W-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk(tag, busy, 0);
    tick();
    chk({tag, "_sb_empty"}, sbq.size(), 0);
  endtask

  task automatic rnd_ops();
    for (int i = 0; i < NR; i++) begin
      a_drv[i] = rnd();
      b_drv[i] = rnd();
    end
  endtask

  // Scoreboard: handshakes push expected products, responses are matched in issue order.
  always @(negedge clk) begin
    if (!rst_n) sbq.delete();
    else begin
      if (rsp_valid) begin
        chk("rsp_expected", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          chk("rsp_id", rsp_id, sbq[0].id);
          chk("rsp_data", rsp_data, sbq[0].p);
          if (rsp_ready) void'(sbq.pop_front());
        end
      end
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i])
          sbq.push_back('{id: IDW'(i), p: prod(a_drv[i], b_drv[i])});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] maxp;
    int exp_g, grants, iss, g;
    bit got;
    maxp = '0;
    maxp = maxp - ({{(2*W-1){1'b0}}, 1'b1} << (W + 1)) + 1;

    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; a_drv = '0; b_drv = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single op: 2*3, issue cycle 0, response cycle 4
    a_drv[0] = 2; b_drv[0] = 3; req_valid = 4'b0001; rsp_ready = 1'b1;
    @(negedge clk);
    chk("t1_ready", req_ready, 4'b0001);
    chk("t1_mul_a", mul_a, 2);
    chk("t1_mul_b", mul_b, 3);
    tick();
    req_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_latency", rsp_valid, (k == 4));
      chk("t1_busy", busy, 1);
    end
    chk("t1_data", rsp_data, 6);
    chk("t1_id", rsp_id, 0);
    wait_idle("t1_idle");

    // Round robin with all requesting
    do_reset();
    tick();
    rnd_ops();
    req_valid = '1; rsp_ready = 1'b1;
    exp_g = 0; grants = 0;
    for (int c = 0; c < 40 && grants < 8; c++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        chk("rr_grant", req_ready, NR'(1) << exp_g);
        exp_g = (exp_g + 1) % NR;
        grants++;
      end
      tick();
      rnd_ops();
    end
    chk("rr_grants", grants, 8);
    req_valid = '0;
    wait_idle("rr_idle");

    // Backpressure: credits cap issues at FIFO depth, then drain and resume
    rnd_ops();
    rsp_ready = 1'b0; req_valid = '1; iss = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready != 0) iss++;
      tick();
      rnd_ops();
    end
    chk("bp_issues", iss, DEP);
    @(negedge clk);
    chk("bp_stalled", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    chk("bp_busy", busy, 1);
    tick();
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_drain", rsp_valid, 1);
      if (req_ready != 0) iss++;
      tick();
      rnd_ops();
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req_ready != 0) iss++;
      tick();
      rnd_ops();
    end
    chk("bp_resume", iss > DEP, 1);
    req_valid = '0;
    wait_idle("bp_idle");

    // Maximum operands
    a_drv[1] = '1; b_drv[1] = '1; req_valid = 4'b0010; got = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready[1]) begin got = 1; break; end
      tick();
    end
    chk("max_grant", got, 1);
    tick();
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("max_prod", rsp_data, maxp);
    chk("max_id", rsp_id, 1);
    wait_idle("max_idle");

    // Fairness between req2 and req3 after a grant to req2
    do_reset();
    tick();
    rnd_ops();
    rsp_ready = 1'b1; req_valid = 4'b0100;
    @(negedge clk);
    chk("fair_first", req_ready, 4'b0100);
    tick();
    req_valid = 4'b1100; g = 0;
    for (int c = 0; c < 20 && g < 4; c++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        chk("fair_seq", req_ready, (g % 2 == 0) ? 4'b1000 : 4'b0100);
        g++;
      end
      tick();
    end
    chk("fair_count", g, 4);
    req_valid = '0;
    wait_idle("fair_idle");

    // Reset with products in flight and buffered
    rnd_ops();
    rsp_ready = 1'b0; req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    chk("mid_pre_busy", busy, 1);
    chk("mid_pre_rsp", rsp_valid, 1);
    tick();
    rst_n = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("mid_no_stale_rsp", rsp_valid, 0);
      chk("mid_no_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
